// File: rtl/id_ex_stage_if.sv
// Bundle of signals between the decode stage, its upstream issue logic and the ALU.
// The decode stage connects through the slave modport; the driver/consumer side uses master.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            fwd_we;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [4:0]      rd;
  logic            rd_we;
  logic            is_branch;
  logic            br_invert;
  logic            illegal;
  logic [XLEN-1:0] pc_q;

  modport slave (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data,
           fwd_we, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, rd_we,
           is_branch, br_invert, illegal, pc_q
  );

  modport master (
    output flush, in_valid, instr, pc, rs1_data, rs2_data,
           fwd_we, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, rd_we,
           is_branch, br_invert, illegal, pc_q
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode/operand stage feeding the ALU through an ID/EX register with valid/ready and flush.
// Define ALU_FWD_EN to substitute the in-flight writeback result for matching source registers.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  pipe_io
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2, ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL = 4'd6, ALU_SRA  = 4'd7,
    ALU_EQ   = 4'd8,  ALU_ULT  = 4'd9,  ALU_UGTE = 4'd10, ALU_SLT = 4'd11,
    ALU_SGTE = 4'd12
  } aluOp_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic aluOp_e arithOp(input logic [2:0] f3, input logic subSel, input logic sraSel);
    case (f3)
      3'd0:    return subSel ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_ULT;
      3'd4:    return ALU_XOR;
      3'd5:    return sraSel ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rdIdx, rs1Idx, rs2Idx;
  logic [XLEN-1:0] immI, immS, immU, shamt;
  logic [XLEN-1:0] rs1Val, rs2Val;
  logic            accept;

  logic            valid_q;
  logic [XLEN-1:0] aluA_q, aluA_d, aluB_q, aluB_d, pcReg_q;
  aluOp_e          aluCtrl_q, aluCtrl_d;
  logic [4:0]      rd_q;
  logic            rdWe_q, rdWe_d, isBranch_q, isBranch_d;
  logic            brInvert_q, brInvert_d, illegal_q, illegal_d;

  assign opcode = pipe_io.instr[6:0];
  assign funct3 = pipe_io.instr[14:12];
  assign rdIdx  = pipe_io.instr[11:7];
  assign rs1Idx = pipe_io.instr[19:15];
  assign rs2Idx = pipe_io.instr[24:20];
  assign immI   = XLEN'($signed(pipe_io.instr[31:20]));
  assign immS   = XLEN'($signed({pipe_io.instr[31:25], pipe_io.instr[11:7]}));
  assign immU   = XLEN'($signed({pipe_io.instr[31:12], 12'b0}));
  assign shamt  = XLEN'(pipe_io.instr[24:20]);

`ifdef ALU_FWD_EN
  assign rs1Val = (pipe_io.fwd_we && pipe_io.fwd_rd != 5'd0 && pipe_io.fwd_rd == rs1Idx)
                  ? pipe_io.fwd_data : pipe_io.rs1_data;
  assign rs2Val = (pipe_io.fwd_we && pipe_io.fwd_rd != 5'd0 && pipe_io.fwd_rd == rs2Idx)
                  ? pipe_io.fwd_data : pipe_io.rs2_data;
`else
  logic unusedFwd;
  assign unusedFwd = ^{pipe_io.fwd_we, pipe_io.fwd_rd, pipe_io.fwd_data, rs1Idx, rs2Idx};
  assign rs1Val    = pipe_io.rs1_data;
  assign rs2Val    = pipe_io.rs2_data;
`endif

  always_comb begin
    aluA_d     = rs1Val;
    aluB_d     = rs2Val;
    aluCtrl_d  = ALU_ADD;
    rdWe_d     = 1'b0;
    isBranch_d = 1'b0;
    brInvert_d = 1'b0;
    illegal_d  = 1'b0;
    case (opcode)
      OPC_OP: begin
        aluCtrl_d = arithOp(funct3, pipe_io.instr[30], pipe_io.instr[30]);
        rdWe_d    = 1'b1;
      end
      OPC_OPIMM: begin
        // Shift immediates carry only the shamt field; funct7 bits select SRA
        aluB_d    = (funct3 == 3'd1 || funct3 == 3'd5) ? shamt : immI;
        aluCtrl_d = arithOp(funct3, 1'b0, pipe_io.instr[30]);
        rdWe_d    = 1'b1;
      end
      OPC_LOAD: begin
        aluB_d = immI;
        rdWe_d = 1'b1;
      end
      OPC_STORE: aluB_d = immS;
      OPC_BRANCH: begin
        isBranch_d = 1'b1;
        case (funct3)
          3'd0: aluCtrl_d = ALU_EQ;
          3'd1: begin
            aluCtrl_d  = ALU_EQ;
            brInvert_d = 1'b1;
          end
          3'd4: aluCtrl_d = ALU_SLT;
          3'd5: aluCtrl_d = ALU_SGTE;
          3'd6: aluCtrl_d = ALU_ULT;
          3'd7: aluCtrl_d = ALU_UGTE;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_LUI: begin
        aluA_d = '0;
        aluB_d = immU;
        rdWe_d = 1'b1;
      end
      OPC_AUIPC: begin
        aluA_d = pipe_io.pc;
        aluB_d = immU;
        rdWe_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    if (rdIdx == 5'd0) rdWe_d = 1'b0;
  end

  assign pipe_io.in_ready = !valid_q || pipe_io.out_ready;
  assign accept           = pipe_io.in_valid && pipe_io.in_ready;

  // Reset beats flush, flush beats accept; payload only moves on accept so holds are free
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluCtrl_q  <= ALU_ADD;
      rd_q       <= '0;
      rdWe_q     <= 1'b0;
      isBranch_q <= 1'b0;
      brInvert_q <= 1'b0;
      illegal_q  <= 1'b0;
      pcReg_q    <= '0;
    end else if (pipe_io.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluCtrl_q  <= aluCtrl_d;
      rd_q       <= rdIdx;
      rdWe_q     <= rdWe_d;
      isBranch_q <= isBranch_d;
      brInvert_q <= brInvert_d;
      illegal_q  <= illegal_d;
      pcReg_q    <= pipe_io.pc;
    end else if (pipe_io.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign pipe_io.out_valid = valid_q;
  assign pipe_io.alu_a     = aluA_q;
  assign pipe_io.alu_b     = aluB_q;
  assign pipe_io.alu_ctrl  = aluCtrl_q;
  assign pipe_io.rd        = rd_q;
  assign pipe_io.rd_we     = rdWe_q;
  assign pipe_io.is_branch = isBranch_q;
  assign pipe_io.br_invert = brInvert_q;
  assign pipe_io.illegal   = illegal_q;
  assign pipe_io.pc_q      = pcReg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode of each instruction class, handshake hold/drain, flush and forwarding.
// Expected values are hand-decoded from the instruction encodings.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic inValid, input logic outReady, input logic flush);
    bus.instr     = instr;
    bus.pc        = pc;
    bus.rs1_data  = rs1;
    bus.rs2_data  = rs2;
    bus.in_valid  = inValid;
    bus.out_ready = outReady;
    bus.flush     = flush;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.fwd_we   = 1'b0;
    bus.fwd_rd   = 5'd0;
    bus.fwd_data = 32'h0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset alu_a", bus.alu_a, 32'd0);
    checkOutput("reset alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
    checkOutput("reset rd_we", {31'b0, bus.rd_we}, 32'd0);
    checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // add x3,x1,x2
    applyStimulus(32'h002081B3, 32'h40, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("add out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("add alu_a", bus.alu_a, 32'd5);
    checkOutput("add alu_b", bus.alu_b, 32'd7);
    checkOutput("add alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
    checkOutput("add rd", {27'b0, bus.rd}, 32'd3);
    checkOutput("add rd_we", {31'b0, bus.rd_we}, 32'd1);
    checkOutput("add pc_q", bus.pc_q, 32'h40);

    // srai x1,x1,4
    applyStimulus(32'h4040D093, 32'h44, 32'h80000000, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("srai alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd7);
    checkOutput("srai alu_b", bus.alu_b, 32'd4);
    checkOutput("srai alu_a", bus.alu_a, 32'h80000000);

    // addi x0,x0,-1
    applyStimulus(32'hFFF00013, 32'h48, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("addi alu_b", bus.alu_b, 32'hFFFFFFFF);
    checkOutput("addi rd_we", {31'b0, bus.rd_we}, 32'd0);

    // bne x1,x2
    applyStimulus(32'h00209063, 32'h4C, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("bne alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd8);
    checkOutput("bne is_branch", {31'b0, bus.is_branch}, 32'd1);
    checkOutput("bne br_invert", {31'b0, bus.br_invert}, 32'd1);
    checkOutput("bne rd_we", {31'b0, bus.rd_we}, 32'd0);

    // stall with sub x4,x1,x2 waiting
    applyStimulus(32'h40208233, 32'h50, 32'd20, 32'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall in_ready", {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall out_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("stall alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd8);
      checkOutput("stall alu_a", bus.alu_a, 32'd9);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    checkOutput("sub alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd1);
    checkOutput("sub alu_a", bus.alu_a, 32'd20);
    checkOutput("sub rd", {27'b0, bus.rd}, 32'd4);
    checkOutput("sub is_branch", {31'b0, bus.is_branch}, 32'd0);

    // lui x5,0x12345 with flush, then without
    applyStimulus(32'h123452B7, 32'h54, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(32'h123452B7, 32'h54, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("lui alu_a", bus.alu_a, 32'd0);
    checkOutput("lui alu_b", bus.alu_b, 32'h12345000);
    checkOutput("lui rd_we", {31'b0, bus.rd_we}, 32'd1);

    // unknown opcode 0x7F with rd=x4
    applyStimulus(32'h0000027F, 32'h58, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("illegal out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("illegal flag", {31'b0, bus.illegal}, 32'd1);
    checkOutput("illegal alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
    checkOutput("illegal rd_we", {31'b0, bus.rd_we}, 32'd0);

    applyStimulus(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("drain out_valid", {31'b0, bus.out_valid}, 32'd0);

    // auipc x3,1 at pc 0x100
    applyStimulus(32'h00001197, 32'h100, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("auipc alu_a", bus.alu_a, 32'h100);
    checkOutput("auipc alu_b", bus.alu_b, 32'h1000);
    checkOutput("auipc illegal", {31'b0, bus.illegal}, 32'd0);

    // sw x2,-4(x1)
    applyStimulus(32'hFE20AE23, 32'h104, 32'h1000, 32'd77, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("sw alu_a", bus.alu_a, 32'h1000);
    checkOutput("sw alu_b", bus.alu_b, 32'hFFFFFFFC);
    checkOutput("sw rd_we", {31'b0, bus.rd_we}, 32'd0);

    // branch funct3=2 is illegal
    applyStimulus(32'h0020A063, 32'h108, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("br f3=2 illegal", {31'b0, bus.illegal}, 32'd1);

    // bltu x1,x2
    applyStimulus(32'h0020E063, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("bltu alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd9);
    checkOutput("bltu br_invert", {31'b0, bus.br_invert}, 32'd0);

    // forwarding onto rs1 of add x3,x1,x2
    bus.fwd_we   = 1'b1;
    bus.fwd_rd   = 5'd1;
    bus.fwd_data = 32'hDEAD;
    applyStimulus(32'h002081B3, 32'h110, 32'd0, 32'd6, 1'b1, 1'b1, 1'b0);
    tick();
`ifdef ALU_FWD_EN
    checkOutput("fwd rs1 alu_a", bus.alu_a, 32'hDEAD);
`else
    checkOutput("fwd ignored alu_a", bus.alu_a, 32'd0);
`endif
    checkOutput("fwd alu_b", bus.alu_b, 32'd6);
    bus.fwd_rd = 5'd0;
    tick();
    checkOutput("fwd x0 alu_a", bus.alu_a, 32'd0);

    rst = 1'b1;
    tick();
    checkOutput("rst out_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage directly upstream of the 32-bit RISC-V ALU.
- Accepts one RV32I instruction plus register-file read data, and decodes it into the ALU's 4-bit control code.
- Selects operand A and operand B (register, immediate, PC or zero), with optional forwarding of the previous result.
- Registers everything into an ID/EX pipeline register with a valid/ready handshake and flush.

Parameters:
- XLEN, 32, datapath width of operands, PC and forwarded data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill pending/accepted instruction (branch redirect).
- in_valid  in  1  instr/pc/rs data valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  raw instruction word.
- pc  in  XLEN  instruction address.
- rs1_data  in  XLEN  register-file read of instr[19:15].
- rs2_data  in  XLEN  register-file read of instr[24:20].
- fwd_we  in  1  downstream result being written this cycle.
- fwd_rd  in  5  destination of that result.
- fwd_data  in  XLEN  that result.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  ALU stage consumes this cycle.
- alu_a  out  XLEN  registered operand A.
- alu_b  out  XLEN  registered operand B.
- alu_ctrl  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 EQ, 9 ULT, 10 UGTE, 11 SLT, 12 SGTE.
- rd  out  5  destination register.
- rd_we  out  1  writes rd; forced 0 when rd==0.
- is_branch  out  1  conditional branch.
- br_invert  out  1  branch taken when ALU result == 0 (BNE).
- illegal  out  1  unrecognised opcode/funct.
- pc_q  out  XLEN  registered pc.

Behaviour:
- Reset: all outputs 0, including out_valid.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready; registered outputs update on that clk edge, so latency is 1 cycle.
- Hold: out_valid && !out_ready keeps all outputs stable.
- Drain: out_ready without accept clears out_valid.
- flush: next edge out_valid=0. Flush beats a simultaneous accept; the incoming instruction is dropped.
- rst beats flush and accept.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: not used as an ALU operand.
  - U: {instr[31:12],12'b0}.
- Decode, by opcode:
  - OP 0110011: a=rs1, b=rs2. funct3 0 gives ADD, or SUB when instr[30]=1. funct3 1 SLL, 2 SLT, 3 ULT, 4 XOR, 5 SRL/SRA (by instr[30]), 6 OR, 7 AND. rd_we=1.
  - OP-IMM 0010011: a=rs1, b=I-imm, same funct3 map. SUB is never selected. funct3 5 uses instr[30] to pick SRA. rd_we=1.
  - LOAD 0000011 / STORE 0100011: ADD, a=rs1. b=I-imm for LOAD, S-imm for STORE. rd_we = LOAD.
  - BRANCH 1100011: a=rs1, b=rs2, is_branch=1, rd_we=0. funct3 0 EQ; 1 EQ with br_invert=1; 4 SLT; 5 SGTE; 6 ULT; 7 UGTE. funct3 2/3 are illegal.
  - LUI 0110111: a=0, b=U-imm, ADD.
  - AUIPC 0010111: a=pc, b=U-imm, ADD.
  - Anything else: illegal=1, alu_ctrl=0, rd_we=0, is_branch=0. out_valid still asserts so the trap reaches downstream.
- rd_we forced 0 when instr[11:7]==0.

Optional Feature:
- ALU_FWD_EN defined:
  - Register operands are substituted with fwd_data when fwd_we && fwd_rd!=0 && fwd_rd matches the source index.
  - Applies to rs1 for a, and rs2 for b in OP/BRANCH. Substitution happens before registering.
- ALU_FWD_EN undefined:
  - fwd_* ports exist but are ignored.
  - Operands come only from rs1_data/rs2_data.

Test Plan:
- rst held 2 cycles, then in_valid=1 with add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, alu_ctrl=0, rd=3, rd_we=1.
- srai x1,x1,4 (0x4040D093), rs1=0x80000000 -> alu_ctrl=7, b=4. addi x0,x0,-1 (0xFFF00013) -> b=0xFFFFFFFF, rd_we=0.
- bne x1,x2 (funct3=1), rs1=rs2=9 -> alu_ctrl=8, is_branch=1, br_invert=1, rd_we=0.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> new instruction accepted same edge.
- flush=1 coincident with accept of lui x5,0x12345 -> out_valid=0 next cycle. Opcode 0x7F -> out_valid=1, illegal=1.
- ALU_FWD_EN: fwd_we=1, fwd_rd=1, fwd_data=0xDEAD, rs1_data=0, instr add x3,x1,x2 -> a=0xDEAD. Same stimulus with fwd_rd=0 -> a=0.
